ltssm_substate_sequencer: RTL and testbench
===========================================

Name: ltssm_substate_sequencer

Overview:
- Drives the 5-bit substate request into the RX LTSSM substate checker and consumes its finish/exitTo handshake to advance training from Detect to L0.
- Handles re-entry of the same substate, failure retries, the speed-change wait, and retrain requests from L0.
- Tracks the current generation and reports linkUp/trainError to the MAC.

Parameters:
- MAX_RETRY, 3, consecutive fall-backs to detectQuiet before trainError (1..7).
- WATCHDOG_CYCLES, 65535, cycles in WAIT without finish before trainError (16-bit counter).
- SPEED_WAIT_CYCLES, 16, cycles spent in recoverywait before issuing recoverySpeedeieos (>=1).
- IDLE_CODE, 31, substate value meaning "no request".

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- startTraining  in  1  one-cycle pulse; begins training from IDLE
- stopTraining  in  1  level; forces IDLE from any state
- retrain  in  1  pulse; in L0, request recovery
- targetGen  in  3  requested generation 1..5
- finish  in  1  checker done strobe
- exitTo  in  5  checker next-substate, valid when finish=1
- substate  out  5  request to checker
- gen  out  3  current operating generation
- trainToGen  out  3  generation being trained to, fed to checker
- linkUp  out  1  high while in L0
- trainError  out  1  sticky until next startTraining
- retryCount  out  3  consecutive detect fall-backs

Behaviour:
- Reset (async, reset=1):
  - FSM=IDLE, substate=IDLE_CODE, gen=1, trainToGen=1.
  - linkUp=0, trainError=0, retryCount=0, watchdog=0, pending=detectQuiet(0).
- All outputs are registered. Substate codes: detectQuiet 0 ... L0 10, recoveryRcvrLock 11, recoverySpeed 13, recoveryIdle 18, recoverySpeedeieos 19, recoverywait 20.
- FSM states:
  - IDLE: substate=IDLE_CODE. On startTraining: clear trainError/retryCount, pending=0, go ISSUE.
  - ISSUE: substate<=pending, watchdog<=0, go WAIT next cycle.
  - WAIT: hold substate, watchdog increments each cycle.
    - finish=1: latch exitTo, go DECIDE.
    - watchdog==WATCHDOG_CYCLES-1 with no finish: trainError=1, go IDLE.
    - finish is sampled only in WAIT; finish seen in any other state is ignored.
  - DECIDE, by latched exitTo:
    - 0 while substate!=0 (failure fall-back): retryCount+1. If new count==MAX_RETRY: trainError=1, go IDLE. Else pending=0, go GAP.
    - 10 (L0): retryCount=0, linkUp=1, substate=10, go L0ST.
    - 20 (recoverywait): gen<=trainToGen, go SPDWAIT.
    - Value >20 and !=IDLE_CODE: trainError=1, go IDLE.
    - Equal to current substate (includes 0->0): pending=exitTo, go GAP.
    - Otherwise: pending=exitTo, go ISSUE.
  - GAP: substate=IDLE_CODE for exactly 1 cycle, then ISSUE. This guarantees the checker sees a new request when the same code is re-issued.
  - L0ST: linkUp=1, substate=10.
    - retrain=1 or targetGen>gen: trainToGen<=max(targetGen,gen), linkUp<=0, pending=11, go GAP.
    - retrain has priority; both conditions in the same cycle produce a single recovery entry.
  - SPDWAIT: substate=20, counter SPEED_WAIT_CYCLES cycles, then pending=19, go ISSUE.
- stopTraining=1 in any state: next cycle FSM=IDLE, substate=IDLE_CODE, linkUp=0. gen and trainError are kept. stopTraining overrides startTraining.
- startTraining outside IDLE is ignored.
- retryCount saturates at MAX_RETRY and clears on reaching L0 or on startTraining.
- targetGen values 0, 6 and 7 are treated as no change. Only 1..5 are latched into trainToGen.
- Latency: exitTo to new substate is 2 cycles via ISSUE (DECIDE, ISSUE), or 3 cycles via GAP.

Test Plan:
- startTraining, checker returns exitTo 0->1->2->...->9->10 -> substate walks 0,1,...,9, each held until finish; linkUp=1 exactly 2 cycles after finish with exitTo=10; gen=1.
- In WAIT for detectQuiet, finish with exitTo=0 -> substate shows 31 for exactly one cycle, then 0 again; retryCount unchanged.
- Three fall-backs from pollingActive(2) to exitTo=0 with MAX_RETRY=3 -> retryCount=1,2, then trainError=1, FSM IDLE, substate=31.
- In L0 with targetGen=3 -> linkUp=0, trainToGen=3, substate 31 then 11. Then exitTo=20 -> gen=3, substate=20 for 16 cycles, then 19.
- No finish for WATCHDOG_CYCLES (set to 100) in WAIT -> trainError=1 at cycle 100, substate=31.
- Assert reset mid-WAIT -> same cycle substate=31, linkUp=0, gen=1. stopTraining in L0 -> linkUp=0 next cycle, gen retained.

Source files
------------

// File: rtl/ltssm_substate_sequencer.sv
// ltssm_substate_sequencer
//
// Steps the RX LTSSM substate checker from Detect to L0. Each substate
// request is driven on substate_o. The checker's finish/exitTo handshake
// picks the next request. The block also handles:
//   - re-issue of the same code, by putting a one-cycle idle gap in front
//   - detect fall-backs, with a retry limit
//   - the recoverywait speed-change dwell
//   - retrain or speed-up requests raised while in L0
//
// Ports
//   clk_i            clock
//   reset_i          asynchronous active-high reset
//   startTraining_i  one-cycle pulse, starts training from IDLE
//   stopTraining_i   level, forces IDLE from any state (beats startTraining_i)
//   retrain_i        pulse, requests recovery while in L0
//   targetGen_i      requested generation 1..5 (0, 6 and 7 mean "no change")
//   finish_i         checker done strobe
//   exitTo_i         checker next substate, valid with finish_i
//   substate_o       substate request to the checker (IDLE_CODE = none)
//   gen_o            current operating generation
//   trainToGen_o     generation being trained to
//   linkUp_o         high while in L0
//   trainError_o     sticky training failure, cleared by startTraining_i
//   retryCount_o     consecutive detect fall-backs
module ltssm_substate_sequencer #(
  parameter int MAX_RETRY         = 3,
  parameter int WATCHDOG_CYCLES   = 65535,
  parameter int SPEED_WAIT_CYCLES = 16,
  parameter int IDLE_CODE         = 31
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       startTraining_i,
  input  logic       stopTraining_i,
  input  logic       retrain_i,
  input  logic [2:0] targetGen_i,
  input  logic       finish_i,
  input  logic [4:0] exitTo_i,
  output logic [4:0] substate_o,
  output logic [2:0] gen_o,
  output logic [2:0] trainToGen_o,
  output logic       linkUp_o,
  output logic       trainError_o,
  output logic [2:0] retryCount_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DECIDE, S_GAP, S_L0, S_SPDWAIT
  } state_e;

  localparam logic [4:0]  IDLE_SUB        = 5'(IDLE_CODE);
  localparam logic [4:0]  SUB_DETECT      = 5'd0;
  localparam logic [4:0]  SUB_L0          = 5'd10;
  localparam logic [4:0]  SUB_RCVR_LOCK   = 5'd11;
  localparam logic [4:0]  SUB_SPEED_EIEOS = 5'd19;
  localparam logic [4:0]  SUB_RCVR_WAIT   = 5'd20;
  localparam logic [2:0]  RETRY_MAX       = 3'(MAX_RETRY);
  localparam logic [15:0] WD_LAST         = 16'(WATCHDOG_CYCLES - 1);
  // The ISSUE cycle that follows SPDWAIT still shows recoverywait.
  // SPDWAIT is therefore one cycle shorter than the visible dwell.
  localparam logic [15:0] SPD_LAST = (SPEED_WAIT_CYCLES >= 2) ?
                                     16'(SPEED_WAIT_CYCLES - 2) : 16'd0;

  state_e      state_q, state_d;
  logic [4:0]  substate_q, substate_d;
  logic [4:0]  pending_q, pending_d;
  logic [4:0]  exit_q, exit_d;
  logic [2:0]  gen_q, gen_d;
  logic [2:0]  trainToGen_q, trainToGen_d;
  logic        linkUp_q, linkUp_d;
  logic        trainError_q, trainError_d;
  logic [2:0]  retryCount_q, retryCount_d;
  logic [15:0] watchdog_q, watchdog_d;
  logic [15:0] spd_cnt_q, spd_cnt_d;

  // Decision terms shared by the next-state and output processes
  logic       fallback, retry_exhausted, exit_invalid;
  logic       tg_valid, tg_higher, recover_req, wd_expired, spd_done;
  logic [2:0] retry_inc, recover_gen;

  // Falling back to detectQuiet from any other substate is a failure.
  // A detectQuiet -> detectQuiet exit is a plain re-entry.
  assign fallback        = (exit_q == SUB_DETECT) && (substate_q != SUB_DETECT);
  assign retry_inc       = retryCount_q + 3'd1;
  assign retry_exhausted = (retry_inc == RETRY_MAX);
  assign exit_invalid    = (exit_q > SUB_RCVR_WAIT) && (exit_q != IDLE_SUB);
  assign tg_valid        = (targetGen_i >= 3'd1) && (targetGen_i <= 3'd5);
  assign tg_higher       = tg_valid && (targetGen_i > gen_q);
  assign recover_req     = retrain_i || tg_higher;
  assign recover_gen     = tg_higher ? targetGen_i : gen_q;
  assign wd_expired      = (watchdog_q == WD_LAST);
  assign spd_done        = (spd_cnt_q >= SPD_LAST);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      substate_q   <= IDLE_SUB;
      pending_q    <= SUB_DETECT;
      exit_q       <= SUB_DETECT;
      gen_q        <= 3'd1;
      trainToGen_q <= 3'd1;
      linkUp_q     <= 1'b0;
      trainError_q <= 1'b0;
      retryCount_q <= 3'd0;
      watchdog_q   <= 16'd0;
      spd_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      substate_q   <= substate_d;
      pending_q    <= pending_d;
      exit_q       <= exit_d;
      gen_q        <= gen_d;
      trainToGen_q <= trainToGen_d;
      linkUp_q     <= linkUp_d;
      trainError_q <= trainError_d;
      retryCount_q <= retryCount_d;
      watchdog_q   <= watchdog_d;
      spd_cnt_q    <= spd_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (startTraining_i) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (finish_i)        state_d = S_DECIDE;
        else if (wd_expired) state_d = S_IDLE;
      end
      S_DECIDE: begin
        if (fallback)                    state_d = retry_exhausted ? S_IDLE : S_GAP;
        else if (exit_q == SUB_L0)        state_d = S_L0;
        else if (exit_q == SUB_RCVR_WAIT) state_d = S_SPDWAIT;
        else if (exit_invalid)            state_d = S_IDLE;
        else if (exit_q == substate_q)    state_d = S_GAP;
        else                              state_d = S_ISSUE;
      end
      S_GAP:     state_d = S_ISSUE;
      S_L0:      if (recover_req) state_d = S_GAP;
      S_SPDWAIT: if (spd_done) state_d = S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
    if (stopTraining_i) state_d = S_IDLE;
  end

  // Output and datapath logic (every output is registered)
  always_comb begin
    substate_d   = substate_q;
    pending_d    = pending_q;
    exit_d       = exit_q;
    gen_d        = gen_q;
    trainToGen_d = trainToGen_q;
    trainError_d = trainError_q;
    retryCount_d = retryCount_q;
    linkUp_d     = (state_d == S_L0);
    watchdog_d   = (state_q == S_WAIT) ? watchdog_q + 16'd1 : 16'd0;
    spd_cnt_d    = (state_q == S_SPDWAIT) ? spd_cnt_q + 16'd1 : 16'd0;

    // The request follows the state being left.
    // GAP shows idle for its single cycle.
    // ISSUE shows the pending code from the next cycle onward.
    if (state_d == S_IDLE) begin
      substate_d = IDLE_SUB;
    end else begin
      unique case (state_q)
        S_GAP:    substate_d = IDLE_SUB;
        S_ISSUE:  substate_d = pending_q;
        S_DECIDE: begin
          if (state_d == S_L0)           substate_d = SUB_L0;
          else if (state_d == S_SPDWAIT) substate_d = SUB_RCVR_WAIT;
        end
        default: ;
      endcase
    end

    if (!stopTraining_i) begin
      unique case (state_q)
        S_IDLE: if (startTraining_i) begin
          trainError_d = 1'b0;
          retryCount_d = 3'd0;
          pending_d    = SUB_DETECT;
        end
        S_WAIT: begin
          if (finish_i)        exit_d       = exitTo_i;
          else if (wd_expired) trainError_d = 1'b1;
        end
        S_DECIDE: begin
          if (fallback) begin
            retryCount_d = (retryCount_q == RETRY_MAX) ? retryCount_q : retry_inc;
            if (retry_exhausted) trainError_d = 1'b1;
            else                 pending_d    = SUB_DETECT;
          end else if (exit_q == SUB_L0) begin
            retryCount_d = 3'd0;
          end else if (exit_q == SUB_RCVR_WAIT) begin
            gen_d = trainToGen_q;
          end else if (exit_invalid) begin
            trainError_d = 1'b1;
          end else begin
            pending_d = exit_q;
          end
        end
        S_L0: if (recover_req) begin
          trainToGen_d = recover_gen;
          pending_d    = SUB_RCVR_LOCK;
        end
        S_SPDWAIT: if (spd_done) pending_d = SUB_SPEED_EIEOS;
        default: ;
      endcase
    end
  end

  assign substate_o   = substate_q;
  assign gen_o        = gen_q;
  assign trainToGen_o = trainToGen_q;
  assign linkUp_o     = linkUp_q;
  assign trainError_o = trainError_q;
  assign retryCount_o = retryCount_q;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Directed bench for ltssm_substate_sequencer.
// Expected substate codes are queued as stimulus is driven.
// A monitor pops the queue each time substate changes.
module tb_ltssm_substate_sequencer;

  logic       clk;
  logic       reset;
  logic       startTraining, stopTraining, retrain, finish;
  logic [2:0] targetGen;
  logic [4:0] exitTo;
  logic [4:0] substate;
  logic [2:0] gen, trainToGen, retryCount;
  logic       linkUp, trainError;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  ltssm_substate_sequencer #(
    .MAX_RETRY(3), .WATCHDOG_CYCLES(100), .SPEED_WAIT_CYCLES(16), .IDLE_CODE(31)
  ) dut (
    .clk_i(clk), .reset_i(reset), .startTraining_i(startTraining),
    .stopTraining_i(stopTraining), .retrain_i(retrain), .targetGen_i(targetGen),
    .finish_i(finish), .exitTo_i(exitTo), .substate_o(substate), .gen_o(gen),
    .trainToGen_o(trainToGen), .linkUp_o(linkUp), .trainError_o(trainError),
    .retryCount_o(retryCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    startTraining = 1'b1;
    step(1);
    startTraining = 1'b0;
  endtask

  task automatic respond(input logic [4:0] code);
    finish = 1'b1;
    exitTo = code;
    step(1);
    finish = 1'b0;
    exitTo = 5'd0;
  endtask

  task automatic wait_sub(input string tag, input logic [4:0] val);
    int n;
    n = 0;
    while (substate !== val && n < 50) begin
      step(1);
      n++;
    end
    check(tag, 32'(substate), 32'(val));
  endtask

  // Scoreboard monitor: every change of substate must match the queue head
  initial begin : monitor
    logic [4:0] prev_sub;
    logic [4:0] exp_sub;
    prev_sub = 5'd31;
    forever begin
      @(negedge clk);
      if (substate !== prev_sub) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sub_unexpected: observed %0d expected none", substate);
        end
        if (exp_q.size() != 0) begin
          exp_sub = exp_q.pop_front();
          check("sub_seq", 32'(substate), 32'(exp_sub));
        end
        prev_sub = substate;
      end
    end
  end

  initial begin : stimulus
    int cnt;
    reset = 1'b1; startTraining = 1'b0; stopTraining = 1'b0; retrain = 1'b0;
    finish = 1'b0; targetGen = 3'd1; exitTo = 5'd0;
    step(2);
    check("rst_sub", 32'(substate), 32'd31);
    check("rst_gen", 32'(gen), 32'd1);
    check("rst_ttg", 32'(trainToGen), 32'd1);
    check("rst_link", 32'(linkUp), 32'd0);
    check("rst_err", 32'(trainError), 32'd0);
    check("rst_retry", 32'(retryCount), 32'd0);
    reset = 1'b0;
    step(1);

    // Detect -> L0 walk
    exp_q.push_back(5'd0);
    pulse_start();
    wait_sub("walk_start", 5'd0);
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(5'(i));
      respond(5'(i));
      step(1);
      check("walk_hold", 32'(substate), 32'(i - 1));
      step(1);
      check("walk_next", 32'(substate), 32'(i));
    end
    exp_q.push_back(5'd10);
    respond(5'd10);
    check("l0_early", 32'(linkUp), 32'd0);
    step(1);
    check("l0_link", 32'(linkUp), 32'd1);
    check("l0_sub", 32'(substate), 32'd10);
    check("l0_gen", 32'(gen), 32'd1);

    // Speed-up request from L0
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd11);
    targetGen = 3'd3;
    step(1);
    check("rec_link", 32'(linkUp), 32'd0);
    check("rec_ttg", 32'(trainToGen), 32'd3);
    step(1);
    check("rec_gap", 32'(substate), 32'd31);
    step(1);
    check("rec_lock", 32'(substate), 32'd11);
    exp_q.push_back(5'd13);
    respond(5'd13);
    wait_sub("rec_speed", 5'd13);
    exp_q.push_back(5'd20);
    exp_q.push_back(5'd19);
    respond(5'd20);
    step(1);
    check("spd_gen", 32'(gen), 32'd3);
    cnt = 0;
    while (substate === 5'd20 && cnt < 40) begin
      cnt++;
      step(1);
    end
    check("spd_len", 32'(cnt), 32'd16);
    check("spd_eieos", 32'(substate), 32'd19);
    exp_q.push_back(5'd10);
    respond(5'd10);
    step(1);
    check("l0g3_link", 32'(linkUp), 32'd1);
    check("l0g3_gen", 32'(gen), 32'd3);
    targetGen = 3'd7;
    step(2);
    check("tg7_link", 32'(linkUp), 32'd1);
    check("tg7_ttg", 32'(trainToGen), 32'd3);

    // stopTraining in L0
    exp_q.push_back(5'd31);
    stopTraining = 1'b1;
    step(1);
    stopTraining = 1'b0;
    check("stop_link", 32'(linkUp), 32'd0);
    check("stop_sub", 32'(substate), 32'd31);
    check("stop_gen", 32'(gen), 32'd3);

    // detectQuiet -> detectQuiet re-entry
    exp_q.push_back(5'd0);
    pulse_start();
    wait_sub("reent_start", 5'd0);
    exp_q.push_back(5'd31);
    exp_q.push_back(5'd0);
    respond(5'd0);
    step(1);
    check("reent_hold", 32'(substate), 32'd0);
    step(1);
    check("reent_gap", 32'(substate), 32'd31);
    step(1);
    check("reent_back", 32'(substate), 32'd0);
    check("reent_retry", 32'(retryCount), 32'd0);

    // Three fall-backs from pollingActive
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(5'd1);
      respond(5'd1);
      wait_sub("fb_1", 5'd1);
      exp_q.push_back(5'd2);
      respond(5'd2);
      wait_sub("fb_2", 5'd2);
      exp_q.push_back(5'd31);
      if (k < 3) exp_q.push_back(5'd0);
      respond(5'd0);
      step(1);
      check("fb_retry", 32'(retryCount), 32'(k));
      check("fb_err", 32'(trainError), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) wait_sub("fb_back", 5'd0);
      else check("fb_idle", 32'(substate), 32'd31);
    end

    // Watchdog expiry
    exp_q.push_back(5'd0);
    pulse_start();
    check("start_clr_err", 32'(trainError), 32'd0);
    check("start_clr_retry", 32'(retryCount), 32'd0);
    step(1);
    check("wd_sub", 32'(substate), 32'd0);
    step(99);
    check("wd_99", 32'(trainError), 32'd0);
    exp_q.push_back(5'd31);
    step(1);
    check("wd_100", 32'(trainError), 32'd1);
    check("wd_sub_idle", 32'(substate), 32'd31);

    // Async reset mid-WAIT
    exp_q.push_back(5'd0);
    pulse_start();
    step(1);
    step(3);
    #2;
    exp_q.push_back(5'd31);
    reset = 1'b1;
    #1;
    check("arst_sub", 32'(substate), 32'd31);
    check("arst_link", 32'(linkUp), 32'd0);
    check("arst_gen", 32'(gen), 32'd1);
    check("arst_ttg", 32'(trainToGen), 32'd1);
    step(1);
    reset = 1'b0;
    step(2);
    check("arst_idle", 32'(substate), 32'd31);

    // stopTraining beats startTraining
    stopTraining = 1'b1;
    startTraining = 1'b1;
    step(1);
    stopTraining = 1'b0;
    startTraining = 1'b0;
    step(2);
    check("stop_over_start", 32'(substate), 32'd31);

    // Out-of-range exitTo
    exp_q.push_back(5'd0);
    pulse_start();
    wait_sub("bad_start", 5'd0);
    exp_q.push_back(5'd31);
    respond(5'd25);
    step(1);
    check("bad_err", 32'(trainError), 32'd1);
    check("bad_sub", 32'(substate), 32'd31);

    step(2);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
